// File: rtl/crc_arbiter.sv
// crc_arbiter: shares one active-low CRC engine between two request channels, round-robin with a RUN watchdog.
// Define CRCARB_FIXED_PRIO_EN for fixed priority (channel 1 wins every tie).
module crc_arbiter #(
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reqEn1_i,
    input  logic              reqEn2_i,
    input  logic [DATA_W-1:0] reqData1_i,
    input  logic [DATA_W-1:0] reqData2_i,
    output logic [1:0]        reqStatus1_o,
    output logic [1:0]        reqStatus2_o,
    output logic              engEn_o,
    output logic [DATA_W-1:0] engData_o,
    input  logic [1:0]        engStatus_i,
    output logic [1:0]        grant_o,
    output logic              timeoutErr_o
);
    typedef enum logic [1:0] {IDLE, ARM, RUN, GAP} state_t;
    localparam logic [7:0] TMO = 8'(TIMEOUT);
    state_t            state_q;
    logic [1:0]        grant_q, served_q, st1_q, st2_q;
    logic              eng_en_q, last_q, tout_q;
    logic [DATA_W-1:0] eng_data_q;
    logic [7:0]        timer_q;
    logic [1:0]        req_en, pend, result;
    logic              pick2, own_en;
    assign req_en = {reqEn2_i, reqEn1_i};
    assign pend   = ~req_en & ~served_q;
`ifdef CRCARB_FIXED_PRIO_EN
    assign pick2  = pend[1] & ~pend[0];
`else
    // last_q=1 means channel 2 owned the engine last, so channel 1 wins a tie
    assign pick2  = pend[1] & (~pend[0] | ~last_q);
`endif
    assign own_en = grant_q[1] ? reqEn2_i : reqEn1_i;
    // a done status beats a simultaneous timeout
    assign result = engStatus_i[1] ? 2'b01 : {1'b0, engStatus_i[0]};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= 2'b00;
            served_q   <= 2'b00;
            st1_q      <= 2'b10;
            st2_q      <= 2'b10;
            eng_en_q   <= 1'b1;
            eng_data_q <= '0;
            last_q     <= 1'b1;
            tout_q     <= 1'b0;
            timer_q    <= 8'd0;
        end else begin
            tout_q <= 1'b0;
            if (reqEn1_i && served_q[0]) begin
                served_q[0] <= 1'b0;
                st1_q       <= 2'b10;
            end
            if (reqEn2_i && served_q[1]) begin
                served_q[1] <= 1'b0;
                st2_q       <= 2'b10;
            end
            case (state_q)
                IDLE: if (|pend) begin
                    grant_q    <= pick2 ? 2'b10 : 2'b01;
                    eng_data_q <= pick2 ? reqData2_i : reqData1_i;
                    eng_en_q   <= 1'b0;
                    timer_q    <= 8'd0;
                    state_q    <= ARM;
                end
                ARM: begin
                    timer_q <= timer_q + 8'd1;
                    state_q <= RUN;
                end
                RUN: if (own_en || !engStatus_i[1] || timer_q == TMO) begin
                    eng_en_q <= 1'b1;
                    last_q   <= grant_q[1];
                    state_q  <= GAP;
                    if (!own_en) begin
                        served_q[grant_q[1]] <= 1'b1;
                        tout_q               <= engStatus_i[1];
                        if (grant_q[1]) st2_q <= result;
                        else st1_q <= result;
                    end
                end else begin
                    timer_q <= timer_q + 8'd1;
                end
                GAP: begin
                    grant_q <= 2'b00;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign reqStatus1_o = st1_q;
    assign reqStatus2_o = st2_q;
    assign engEn_o      = eng_en_q;
    assign engData_o    = eng_data_q;
    assign grant_o      = grant_q;
    assign timeoutErr_o = tout_q;
endmodule

// File: tb/tb_crc_arbiter.sv
// tb_crc_arbiter: directed checks of crc_arbiter with TIMEOUT=8.
module tb_crc_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        en1 = 1'b1, en2 = 1'b1;
    logic [63:0] d1 = '0, d2 = '0;
    logic [1:0]  est = 2'b10;
    logic [1:0]  st1, st2, grant;
    logic        eng_en, tout;
    logic [63:0] eng_data;
    int          checks = 0, errors = 0;
`ifdef CRCARB_FIXED_PRIO_EN
    localparam logic [1:0] G2 = 2'b01;
`else
    localparam logic [1:0] G2 = 2'b10;
`endif
    localparam logic [63:0] A = 64'h1111_2222_3333_4444;
    localparam logic [63:0] B = 64'h5555_6666_7777_8888;
    crc_arbiter #(.DATA_W(64), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .reqEn1_i(en1), .reqEn2_i(en2),
        .reqData1_i(d1), .reqData2_i(d2),
        .reqStatus1_o(st1), .reqStatus2_o(st2),
        .engEn_o(eng_en), .engData_o(eng_data),
        .engStatus_i(est), .grant_o(grant), .timeoutErr_o(tout)
    );
    always #5 clk = ~clk;
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    initial begin
        step(2);
        chk("rst_engEn", eng_en, 1);
        chk("rst_engData", eng_data, 0);
        chk("rst_grant", grant, 2'b00);
        chk("rst_st1", st1, 2'b10);
        chk("rst_st2", st2, 2'b10);
        chk("rst_tout", tout, 0);
        rst = 1'b0;
        // single request, done 5 cycles after grant
        en1 = 1'b0; d1 = 64'hDEADBEEF_00000001;
        step();
        chk("t1_grant", grant, 2'b01);
        chk("t1_engEn", eng_en, 0);
        chk("t1_engData", eng_data, 64'hDEADBEEF_00000001);
        step(4);
        chk("t1_wait_st1", st1, 2'b10);
        est = 2'b00;
        step();
        chk("t1_done_st1", st1, 2'b00);
        chk("t1_done_engEn", eng_en, 1);
        est = 2'b10;
        step();
        chk("t1_hold_st1", st1, 2'b00);
        chk("t1_gap_grant", grant, 2'b00);
        en1 = 1'b1;
        step();
        chk("t1_release_st1", st1, 2'b10);
        // simultaneous requests after reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        en1 = 1'b0; en2 = 1'b0; d1 = A; d2 = B;
        step();
        chk("t2_first_grant", grant, 2'b01);
        chk("t2_first_data", eng_data, A);
        step(2);
        est = 2'b00;
        step();
        chk("t2_first_st1", st1, 2'b00);
        chk("t2_first_st2", st2, 2'b10);
        est = 2'b10; en1 = 1'b1;
        step();
        chk("t2_rel_st1", st1, 2'b10);
        en1 = 1'b0;
        step();
        chk("t2_second_grant", grant, G2);
        chk("t2_second_data", eng_data, G2 == 2'b10 ? B : A);
        step(2);
        est = 2'b00;
        step();
        chk("t2_second_st1", st1, G2 == 2'b01 ? 2'b00 : 2'b10);
        chk("t2_second_st2", st2, G2 == 2'b10 ? 2'b00 : 2'b10);
        est = 2'b10; en1 = 1'b1; en2 = 1'b1;
        step();
        en1 = 1'b0; en2 = 1'b0;
        step();
        chk("t2_third_grant", grant, 2'b01);
        // engine error, stale done during ARM ignored
        est = 2'b00;
        step();
        chk("t3_arm_engEn", eng_en, 0);
        chk("t3_arm_st1", st1, 2'b10);
        est = 2'b01;
        step();
        chk("t3_err_st1", st1, 2'b01);
        chk("t3_err_st2", st2, 2'b10);
        chk("t3_err_engEn", eng_en, 1);
        est = 2'b10; en1 = 1'b1;
        step();
        chk("t3_rel_st1", st1, 2'b10);
        step();
        chk("t4_grant2", grant, 2'b10);
        chk("t4_data2", eng_data, B);
        step(2);
        // withdraw in the same cycle as done
        en2 = 1'b1; en1 = 1'b0; est = 2'b00;
        step();
        chk("t4_abort_engEn", eng_en, 1);
        chk("t4_abort_st2", st2, 2'b10);
        chk("t4_abort_tout", tout, 0);
        est = 2'b10;
        step(2);
        chk("t4_next_grant", grant, 2'b01);
        // watchdog with TIMEOUT=8
        step(8);
        chk("t5_pre_tout", tout, 0);
        chk("t5_pre_engEn", eng_en, 0);
        step();
        chk("t5_tout", tout, 1);
        chk("t5_st1", st1, 2'b01);
        chk("t5_engEn", eng_en, 1);
        step();
        chk("t5_tout_pulse", tout, 0);
        chk("t5_hold_st1", st1, 2'b01);
        // asynchronous reset mid-RUN
        en1 = 1'b1;
        step();
        en1 = 1'b0;
        step();
        chk("t6_grant", grant, 2'b01);
        step(2);
        #2 rst = 1'b1;
        #1;
        chk("t6_engEn", eng_en, 1);
        chk("t6_grant0", grant, 2'b00);
        chk("t6_engData", eng_data, 0);
        chk("t6_st1", st1, 2'b10);
        chk("t6_st2", st2, 2'b10);
        step();
        rst = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
